// File: rtl/qspi_cmd_sequencer.sv
// qspi_cmd_sequencer: upstream command sequencer for a QSPI master.
// Host requests are buffered in a small FIFO and issued one at a time as a single-cycle
// start pulse with held command fields. Write-class opcodes (02, 38, 01) are preceded by
// an automatic WREN (06). The master has no busy flag, so its progress is tracked by
// watching its active-low chip select.
//
// Ports:
//   clk_i, reset_i            clock; synchronous active-high reset
//   req_valid_i / req_ready_o host push handshake (push = valid & ready)
//   req_opcode_i, req_addr_i, req_wdata_i, req_burst_i   request fields
//   busy_o                    FIFO non-empty or sequencer not idle (registered)
//   err_timeout_o             one-cycle pulse when CS never fell after a start
//   start_o                   one-cycle start pulse to the master
//   opcode_o, address_o, write_data_o, burst_len_o       held command fields
//   cs_i                      master chip select, active-low, same clock domain
module qspi_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 12,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_opcode_i,
  input  logic [23:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  input  logic [3:0]  req_burst_i,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic        start_o,
  output logic [7:0]  opcode_o,
  output logic [23:0] address_o,
  output logic [7:0]  write_data_o,
  output logic [3:0]  burst_len_o,
  input  logic        cs_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES);

  localparam logic [7:0] OpWren = 8'h06;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  burst;
  } req_t;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StGap} state_e;

  function automatic logic is_write(input logic [7:0] op);
    return (op == 8'h02) || (op == 8'h38) || (op == 8'h01);
  endfunction

  // FIFO storage and pointers
  req_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  req_t            head;

  // Sequencer state
  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            need_main_q, need_main_d;
  req_t            cur_q, cur_d;
  req_t            out_q, out_d;
  logic            busy_q;
  logic            err_pulse;

  assign req_ready_o = (count_q != CntW'(FIFO_DEPTH));
  assign push        = req_valid_i & req_ready_o;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op: req_opcode_i, addr: req_addr_i, wdata: req_wdata_i,
                           burst: req_burst_i};
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    need_main_d = need_main_q;
    cur_d       = cur_q;
    out_d       = out_q;
    pop         = 1'b0;
    err_pulse   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          cur_d = head;
          if (is_write(head.op)) begin
            // WREN goes first; only the opcode changes, the other fields keep their values.
            need_main_d = 1'b1;
            out_d.op    = OpWren;
          end else begin
            out_d = head;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!cs_i) begin
          state_d = StWaitHi;
        end else if (tmo_q == TmoW'(TIMEOUT)) begin
          // Master never selected the flash: abandon the rest of this request.
          err_pulse   = 1'b1;
          need_main_d = 1'b0;
          gap_d       = '0;
          state_d     = StGap;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitHi: begin
        if (cs_i) begin
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          if (need_main_q) begin
            out_d       = cur_q;
            need_main_d = 1'b0;
            state_d     = StIssue;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      tmo_q       <= '0;
      gap_q       <= '0;
      need_main_q <= 1'b0;
      cur_q       <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      need_main_q <= need_main_d;
      cur_q       <= cur_d;
      out_q       <= out_d;
      // Built from next-state values so the flop tracks the current count/state exactly.
      busy_q      <= (count_d != '0) || (state_d != StIdle);
    end
  end

  assign start_o       = (state_q == StIssue);
  assign err_timeout_o = err_pulse;
  assign busy_o        = busy_q;
  assign opcode_o      = out_q.op;
  assign address_o     = out_q.addr;
  assign write_data_o  = out_q.wdata;
  assign burst_len_o   = out_q.burst;

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Bench for qspi_cmd_sequencer: directed scenarios with randomized fields and master timing,
// checked against a transaction-level model (request queue + expected start schedule).
module tb_qspi_cmd_sequencer;
  localparam int GAP = 12;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, start, busy, err, cs;
  logic [7:0]  req_opcode, req_wdata, opcode, write_data;
  logic [23:0] req_addr, address;
  logic [3:0]  req_burst, burst_len;

  always #5 clk = ~clk;

  qspi_cmd_sequencer #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_opcode_i (req_opcode),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_burst_i  (req_burst),
    .busy_o       (busy),
    .err_timeout_o(err),
    .start_o      (start),
    .opcode_o     (opcode),
    .address_o    (address),
    .write_data_o (write_data),
    .burst_len_o  (burst_len),
    .cs_i         (cs)
  );

  typedef struct {
    logic [43:0] f;
    int          pc;
  } entry_t;

  entry_t      req_q[$];
  int          cyc, last_end, start_cyc, last_push;
  int          n_starts, n_errs, hold_errs, ready_errs;
  int          n_checks, n_pass;
  logic        pending_main, in_txn, cs_fell, prev_busy;
  logic [43:0] main_f, held;
  logic        cs_dead;
  int          lo_len;

  logic [7:0] ops [7] = '{8'h03, 8'hEB, 8'h02, 8'h38, 8'h01, 8'h06, 8'h9F};

  function automatic bit is_wr(input logic [7:0] op);
    return (op == 8'h02) || (op == 8'h38) || (op == 8'h01);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Master stand-in: some cycles after a start it drops CS for a while, then raises it.
  initial begin
    int d, l;
    cs = 1'b1;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && !cs_dead) begin
        d = $urandom_range(1, 4);
        l = (lo_len > 0) ? lo_len : $urandom_range(2, 16);
        repeat (d) @(posedge clk);
        #1 cs = 1'b0;
        repeat (l) @(posedge clk);
        #1 cs = 1'b1;
      end
    end
  end

  // Reference model and monitor, sampled mid-cycle.
  initial begin
    logic [43:0] ef, obs_f;
    int          ec;
    entry_t      e;
    logic        have;
    cyc = 0; last_end = -1000; start_cyc = 0; last_push = -1000;
    n_starts = 0; n_errs = 0; hold_errs = 0; ready_errs = 0;
    pending_main = 1'b0; in_txn = 1'b0; cs_fell = 1'b0; prev_busy = 1'b0;
    held = '0; main_f = '0;
    forever begin
      @(negedge clk);
      cyc++;
      obs_f = {opcode, address, write_data, burst_len};
      if (start === 1'b1) begin
        have = pending_main || (req_q.size() != 0);
        chk("start_expected", have, 1'b1);
        if (have) begin
          if (pending_main) begin
            ef = main_f;
            ec = last_end + GAP + 1;
            pending_main = 1'b0;
          end else begin
            e = req_q.pop_front();
            ec = (e.pc + 2 > last_end + GAP + 2) ? e.pc + 2 : last_end + GAP + 2;
            if (is_wr(e.f[43:36])) begin
              ef = {8'h06, held[35:0]};
              main_f = e.f;
              pending_main = 1'b1;
            end else begin
              ef = e.f;
            end
          end
          chk("start_fields", obs_f, ef);
          chk("start_cycle", cyc, ec);
          held = ef;
        end
        start_cyc = cyc;
        in_txn = 1'b1;
        cs_fell = 1'b0;
        n_starts++;
      end else if (obs_f !== held) begin
        hold_errs++;
      end
      if (err === 1'b1) begin
        chk("err_in_txn", in_txn, 1'b1);
        chk("err_cycle", cyc - start_cyc, TMO + 1);
        chk("err_cs_dead", cs_dead, 1'b1);
        n_errs++;
        pending_main = 1'b0;
        in_txn = 1'b0;
        last_end = cyc;
      end
      if (in_txn && cs === 1'b0) cs_fell = 1'b1;
      if (in_txn && cs_fell && cs === 1'b1) begin
        in_txn = 1'b0;
        cs_fell = 1'b0;
        last_end = cyc;
      end
      if (busy !== prev_busy) begin
        if (busy === 1'b1) chk("busy_rise_cycle", cyc, last_push + 1);
        else chk("busy_fall_cycle", cyc, last_end + GAP + 1);
      end
      prev_busy = busy;
      if (req_ready !== (req_q.size() != 4)) ready_errs++;
      if (reset === 1'b1) begin
        req_q.delete();
        pending_main = 1'b0; in_txn = 1'b0; cs_fell = 1'b0; prev_busy = 1'b0;
        held = '0; last_end = -1000;
      end else if (req_valid && req_ready) begin
        e.f = {req_opcode, req_addr, req_wdata, req_burst};
        e.pc = cyc;
        req_q.push_back(e);
        last_push = cyc;
      end
    end
  end

  task automatic push_req(input logic [7:0] op, input logic [23:0] a, input logic [7:0] wd,
                          input logic [3:0] b);
    int   guard = 0;
    logic acc;
    req_opcode = op; req_addr = a; req_wdata = wd; req_burst = b;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 5000);
    if (!acc) chk("push_accept", acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && !in_txn && cs === 1'b1) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk("idle_reached", quiet, 4);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_starts < target) chk("start_seen", n_starts, target);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          s0, e0, exp_n, n;
    logic [7:0]  op;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; req_valid = 1'b0;
    req_opcode = '0; req_addr = '0; req_wdata = '0; req_burst = '0;
    cs_dead = 1'b0; lo_len = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_start", start, 1'b0);
    chk("rst_fields", {opcode, address, write_data, burst_len}, 44'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);

    // Plain read
    s0 = n_starts;
    push_req(8'h03, 24'h000100, 8'($urandom), 4'h0);
    wait_idle(400);
    chk("t1_starts", n_starts - s0, 1);

    // Page program gets a WREN first
    s0 = n_starts;
    push_req(8'h02, 24'h000010, 8'hA5, 4'($urandom));
    wait_idle(400);
    chk("t2_starts", n_starts - s0, 2);

    // Fill the FIFO while the sequencer is stuck in a long transaction
    s0 = n_starts;
    exp_n = 1;
    lo_len = 40;
    push_req(8'h03, 24'($urandom), 8'($urandom), 4'($urandom));
    wait_start(s0 + 1, 50);
    for (int i = 0; i < 4; i++) begin
      op = ops[$urandom_range(0, 6)];
      exp_n += is_wr(op) ? 2 : 1;
      push_req(op, 24'($urandom), 8'($urandom), 4'($urandom));
    end
    chk("t3_full_ready", req_ready, 1'b0);
    lo_len = 0;
    op = ops[$urandom_range(0, 6)];
    exp_n += is_wr(op) ? 2 : 1;
    push_req(op, 24'($urandom), 8'($urandom), 4'($urandom));
    wait_idle(3000);
    chk("t3_starts", n_starts - s0, exp_n);

    // Random traffic with random spacing
    s0 = n_starts;
    exp_n = 0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      op = ops[$urandom_range(0, 6)];
      exp_n += is_wr(op) ? 2 : 1;
      push_req(op, 24'($urandom), 8'($urandom), 4'($urandom));
    end
    wait_idle(4000);
    chk("t4_starts", n_starts - s0, exp_n);

    // No master: CS never falls
    s0 = n_starts;
    e0 = n_errs;
    cs_dead = 1'b1;
    push_req(8'h9F, 24'($urandom), 8'($urandom), 4'($urandom));
    wait_idle(3000);
    chk("t5_err_count", n_errs - e0, 1);
    chk("t5_starts", n_starts - s0, 1);
    cs_dead = 1'b0;

    // Reset during the WREN's CS-low window of a 0x38
    s0 = n_starts;
    lo_len = 60;
    push_req(8'h38, 24'($urandom), 8'($urandom), 4'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs !== 1'b0 && n < 100);
    chk("t6_cs_low", cs, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t6_start", start, 1'b0);
    chk("t6_fields", {opcode, address, write_data, burst_len}, 44'h0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", req_ready, 1'b1);
    lo_len = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("t6_starts", n_starts - s0, 1);
    chk("t6_busy_late", busy, 1'b0);

    // 0x06 from the host is issued as-is
    s0 = n_starts;
    push_req(8'hEB, 24'($urandom), 8'($urandom), 4'($urandom));
    push_req(8'h06, 24'($urandom), 8'($urandom), 4'($urandom));
    wait_idle(600);
    chk("t7_starts", n_starts - s0, 2);

    chk("hold_errs", hold_errs, 0);
    chk("ready_errs", ready_errs, 0);
    chk("model_drained", req_q.size() + int'(pending_main), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
